// File: rtl/serial_subtractor_4.sv
// Bit-serial subtractor: a - b - borrow_in, LSB first, one bit per clock, start/busy/done handshake.
// Optional signed-overflow output is enabled by defining SUB_OVERFLOW_EN.
module serial_subtractor_4 #(
   parameter int WIDTH = 4
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             start_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             borrow_in,
   output logic             busy_out,
   output logic             done_out,
   output logic [WIDTH-1:0] diff_out,
   output logic             borrow_out
`ifdef SUB_OVERFLOW_EN
   ,
   output logic             overflow_out
`endif
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             br_q, br_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
`ifdef SUB_OVERFLOW_EN
   logic             ovf_q, ovf_d;
`endif

   logic bit_a, bit_b, d_bit, br_next;

   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_d    = res_q;
      br_d     = br_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
`ifdef SUB_OVERFLOW_EN
      ovf_d    = ovf_q;
`endif

      bit_a   = a_sh_q[0];
      bit_b   = b_sh_q[0];
      d_bit   = bit_a ^ bit_b ^ br_q;
      br_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);

      case (state_q)
         IDLE, DONE: begin
            if (start_in) begin
               a_sh_d  = a_in;
               b_sh_d  = b_in;
               br_d    = borrow_in;
               res_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            res_d  = {d_bit, res_q[WIDTH-1:1]};
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            br_d   = br_next;
            if (cnt_q == CW'(WIDTH - 1)) begin
               // Results are captured only here, so they hold steady through any later RUN.
               state_d  = DONE;
               diff_d   = {d_bit, res_q[WIDTH-1:1]};
               borrow_d = br_next;
`ifdef SUB_OVERFLOW_EN
               ovf_d    = (bit_a != bit_b) && (d_bit != bit_a);
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; reset clears every register, shift registers included.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_q    <= '0;
         br_q     <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_q    <= res_d;
         br_q     <= br_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
`ifdef SUB_OVERFLOW_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy_out   = (state_q == RUN);
   assign done_out   = (state_q == DONE);
   assign diff_out   = diff_q;
   assign borrow_out = borrow_q;
`ifdef SUB_OVERFLOW_EN
   assign overflow_out = ovf_q;
`endif

endmodule
